// File: rtl/zicfilp_elp_tracker_pkg.sv
// -----------------------------------------------------------------------------
// zicfilp_elp_tracker_pkg
// Shared types and constants for the Zicfilp landing-pad tracker:
//   - elp_t        : architectural expected-landing-pad state
//   - cfi_status_e : branch-unit completion status for a retiring LPAD
//   - exception_t  : exception record handed to the commit stage
//   - lp_state_e   : tracker FSM encoding
// -----------------------------------------------------------------------------
package zicfilp_elp_tracker_pkg;

  localparam int unsigned XLEN = 64;

  typedef enum logic {
    NO_LP_EXPECTED = 1'b0,
    LP_EXPECTED    = 1'b1
  } elp_t;

  // Software-check exception cause and its landing-pad tval code
  localparam logic [XLEN-1:0] CAUSE_SW_CHECK = 64'd18;
  localparam logic [XLEN-1:0] LPAD_FAULT     = 64'd2;

  typedef enum logic [1:0] {
    CFI_MISMATCH = 2'b00,
    CFI_OFF      = 2'b01,
    CFI_NOCHECK  = 2'b10,
    CFI_MATCH    = 2'b11
  } cfi_status_e;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic [XLEN-1:0] tval2;
    logic [31:0]     tinst;
    logic            gva;
    logic            valid;
  } exception_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_FAULT = 2'b10
  } lp_state_e;

  // x1/x5 are link registers (returns), x7 is the software-guarded jump
  // register; indirect jumps through them do not require a landing pad.
  function automatic logic rs1_exempt(input logic [4:0] rs1);
    return (rs1 == 5'd1) || (rs1 == 5'd5) || (rs1 == 5'd7);
  endfunction

  // Exception record for a missing landing pad
  function automatic exception_t lp_fault_exc();
    exception_t e;
    e       = '0;
    e.cause = CAUSE_SW_CHECK;
    e.tval  = LPAD_FAULT;
    e.valid = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/zicfilp_elp_tracker.sv
// -----------------------------------------------------------------------------
// zicfilp_elp_tracker
// Commit-side owner of the Zicfilp ELP state. Arms on a committed indirect
// jump, checks that the next committed instruction is a matching LPAD, raises
// a software-check fault otherwise, and saves/restores ELP through xPELP on
// traps and xRET.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   xlpad_i               landing pads enabled at current privilege
//   debug_mode_i          core in debug mode (no arming, no faults)
//   commit_*              retiring instruction info (valid, jalr, rs1, lpad)
//   complete_cfi_i        branch-unit CFI status of the retiring instruction
//   trap_taken_i, xret_i  trap entry / MRET-SRET retirement
//   pelp_i                xPELP of the privilege being returned to
//   elp_o                 current ELP toward the branch unit
//   pelp_o, pelp_we_o     value and one-cycle strobe for xPELP write
//   lp_exception_o        landing-pad fault toward commit
//   lp_fault_cnt_o        saturating landing-pad fault counter
// -----------------------------------------------------------------------------
module zicfilp_elp_tracker
  import zicfilp_elp_tracker_pkg::*;
#(
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                xlpad_i,
  input  logic                debug_mode_i,
  input  logic                commit_valid_i,
  input  logic                commit_is_jalr_i,
  input  logic [4:0]          commit_rs1_i,
  input  logic                commit_is_lpad_i,
  input  logic [1:0]          complete_cfi_i,
  input  logic                trap_taken_i,
  input  logic                xret_i,
  input  logic                pelp_i,
  output elp_t                elp_o,
  output logic                pelp_o,
  output logic                pelp_we_o,
  output exception_t          lp_exception_o,
  output logic [CntWidth-1:0] lp_fault_cnt_o
);

  localparam logic [CntWidth-1:0] CNT_MAX = {CntWidth{1'b1}};
  localparam logic [CntWidth-1:0] CNT_ONE = CntWidth'(1);

  lp_state_e           state_q, state_d;
  elp_t                elp_q, elp_d;
  logic                pelp_q, pelp_d;
  logic                pelp_we_q, pelp_we_d;
  exception_t          exc_q, exc_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [CntWidth-1:0] cnt_inc_s;
  cfi_status_e         cfi_s;

  assign cfi_s     = cfi_status_e'(complete_cfi_i);
  assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

  // Next-state and output computation; priority trap > xret > debug > commit
  always_comb begin
    state_d   = state_q;
    pelp_d    = 1'b0;
    pelp_we_d = 1'b0;
    exc_d     = exc_q;
    cnt_d     = cnt_q;

    if (trap_taken_i) begin
      // The trapping instruction does not retire, so a coincident commit is ignored
      pelp_d    = (state_q != ST_IDLE);
      pelp_we_d = 1'b1;
      state_d   = ST_IDLE;
      exc_d     = '0;
    end else if (state_q == ST_FAULT) begin
      // A pending fault is only resolved by the trap it provokes (or reset)
      state_d = ST_FAULT;
    end else if (xret_i) begin
      state_d   = (pelp_i && xlpad_i) ? ST_ARMED : ST_IDLE;
      pelp_d    = 1'b0;
      pelp_we_d = 1'b1;
    end else if (debug_mode_i || !xlpad_i) begin
      state_d = ST_IDLE;
    end else if (commit_valid_i) begin
      case (state_q)
        ST_IDLE: begin
          if (commit_is_jalr_i && !rs1_exempt(commit_rs1_i)) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (commit_is_lpad_i) begin
            if (cfi_s == CFI_MISMATCH) begin
              // Branch unit already raised this one; only count it
              state_d = ST_FAULT;
              cnt_d   = cnt_inc_s;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            // Missing landing pad; a JALR here faults and does not re-arm
            state_d = ST_FAULT;
            exc_d   = lp_fault_exc();
            cnt_d   = cnt_inc_s;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end

    elp_d = (state_d == ST_IDLE) ? NO_LP_EXPECTED : LP_EXPECTED;
  end

  // State and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      elp_q     <= NO_LP_EXPECTED;
      pelp_q    <= 1'b0;
      pelp_we_q <= 1'b0;
      exc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      elp_q     <= elp_d;
      pelp_q    <= pelp_d;
      pelp_we_q <= pelp_we_d;
      exc_q     <= exc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign elp_o          = elp_q;
  assign pelp_o         = pelp_q;
  assign pelp_we_o      = pelp_we_q;
  assign lp_exception_o = exc_q;
  assign lp_fault_cnt_o = cnt_q;

endmodule

// File: tb/tb_zicfilp_elp_tracker.sv
module tb_zicfilp_elp_tracker;
  import zicfilp_elp_tracker_pkg::*;

  localparam int CW = 3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          xlpad_i, debug_mode_i, commit_valid_i, commit_is_jalr_i;
  logic [4:0]    commit_rs1_i;
  logic          commit_is_lpad_i;
  logic [1:0]    complete_cfi_i;
  logic          trap_taken_i, xret_i, pelp_i;
  elp_t          elp_o;
  logic          pelp_o, pelp_we_o;
  exception_t    lp_exception_o;
  logic [CW-1:0] lp_fault_cnt_o;

  zicfilp_elp_tracker #(.CntWidth(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .xlpad_i(xlpad_i), .debug_mode_i(debug_mode_i),
    .commit_valid_i(commit_valid_i), .commit_is_jalr_i(commit_is_jalr_i),
    .commit_rs1_i(commit_rs1_i), .commit_is_lpad_i(commit_is_lpad_i),
    .complete_cfi_i(complete_cfi_i), .trap_taken_i(trap_taken_i), .xret_i(xret_i),
    .pelp_i(pelp_i), .elp_o(elp_o), .pelp_o(pelp_o), .pelp_we_o(pelp_we_o),
    .lp_exception_o(lp_exception_o), .lp_fault_cnt_o(lp_fault_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int            tag;
    logic          elp;
    logic          pelp;
    logic          we;
    logic          exv;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  logic stim_done = 1'b0;
  int   tag_n = 0;

  task automatic chk(input int tag, input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL step%0d %s: got %0h want %0h", tag, nm, act, want);
    end
  endtask

  // Monitor: pops one expectation per output sample and compares
  initial begin : monitor
    int   cyc;
    exp_t e;
    cyc = 0;
    forever begin
      @(posedge clk_i or posedge rst_i);
      #2;
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.tag, "elp",     64'(elp_o),                e.elp);
        chk(e.tag, "pelp",    64'(pelp_o),               e.pelp);
        chk(e.tag, "pelp_we", 64'(pelp_we_o),            e.we);
        chk(e.tag, "exc_vld", 64'(lp_exception_o.valid), e.exv);
        chk(e.tag, "cause",   lp_exception_o.cause,      e.exv ? 64'd18 : 64'd0);
        chk(e.tag, "tval",    lp_exception_o.tval,       e.exv ? 64'd2  : 64'd0);
        chk(e.tag, "tval2",   lp_exception_o.tval2,      64'd0);
        chk(e.tag, "cnt",     64'(lp_fault_cnt_o),       64'(e.cnt));
      end else if (stim_done) begin
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
      if (cyc > 5000) begin
        total++;
        bad++;
        $display("FAIL watchdog: got %0d cycles want <= 5000", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  task automatic push(input logic e_elp, input logic e_pelp, input logic e_we,
                      input logic e_exv, input logic [CW-1:0] e_cnt);
    exp_t e;
    tag_n++;
    e.tag = tag_n; e.elp = e_elp; e.pelp = e_pelp; e.we = e_we; e.exv = e_exv; e.cnt = e_cnt;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of inputs and queue the response expected after the next edge
  task automatic vec(input logic cv, input logic jalr, input logic [4:0] rs1,
                     input logic lpad, input logic [1:0] cfi, input logic trap,
                     input logic xret, input logic pin, input logic dbg, input logic xl,
                     input logic e_elp, input logic e_pelp, input logic e_we,
                     input logic e_exv, input logic [CW-1:0] e_cnt);
    @(negedge clk_i);
    commit_valid_i = cv; commit_is_jalr_i = jalr; commit_rs1_i = rs1;
    commit_is_lpad_i = lpad; complete_cfi_i = cfi; trap_taken_i = trap;
    xret_i = xret; pelp_i = pin; debug_mode_i = dbg; xlpad_i = xl;
    push(e_elp, e_pelp, e_we, e_exv, e_cnt);
  endtask

  task automatic idle_in();
    commit_valid_i = 1'b0; commit_is_jalr_i = 1'b0; commit_rs1_i = 5'd0;
    commit_is_lpad_i = 1'b0; complete_cfi_i = 2'b10; trap_taken_i = 1'b0;
    xret_i = 1'b0; pelp_i = 1'b0; debug_mode_i = 1'b0; xlpad_i = 1'b1;
  endtask

  initial begin : stim
    logic [CW-1:0] c;
    idle_in();
    push(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);          // reset state
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    //   cv   jalr rs1    lpad cfi    trap xret pin  dbg  xl   | elp pelp we  exv cnt
    vec(1'b0,1'b0,5'd0, 1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,3'd0);
    vec(1'b1,1'b1,5'd10,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,3'd0);
    vec(1'b1,1'b0,5'd0, 1'b1,2'b11,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,3'd0);
    // missing LPAD -> exception held until trap
    vec(1'b1,1'b1,5'd10,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,3'd0);
    vec(1'b1,1'b0,5'd3, 1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1,3'd1);
    vec(1'b0,1'b0,5'd0, 1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1,3'd1);
    vec(1'b1,1'b0,5'd0, 1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1,3'd1);
    vec(1'b0,1'b0,5'd0, 1'b0,2'b10,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b1,1'b0,3'd1);
    vec(1'b0,1'b0,5'd0, 1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,3'd1);
    // exempt rs1 values never arm
    vec(1'b1,1'b1,5'd5, 1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,3'd1);
    vec(1'b1,1'b0,5'd3, 1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,3'd1);
    vec(1'b1,1'b1,5'd7, 1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,3'd1);
    vec(1'b1,1'b0,5'd3, 1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,3'd1);
    vec(1'b1,1'b1,5'd1, 1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,3'd1);
    // interrupt while ARMED, then xret restores ELP
    vec(1'b1,1'b1,5'd10,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,3'd1);
    vec(1'b0,1'b0,5'd0, 1'b0,2'b10,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b1,1'b0,3'd1);
    vec(1'b0,1'b0,5'd0, 1'b0,2'b10,1'b0,1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0,3'd1);
    vec(1'b1,1'b0,5'd0, 1'b1,2'b11,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,3'd1);
    // label mismatch: counted, no exception from this block
    vec(1'b1,1'b1,5'd10,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,3'd1);
    vec(1'b1,1'b0,5'd0, 1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,3'd2);
    vec(1'b0,1'b0,5'd0, 1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,3'd2);
    vec(1'b0,1'b0,5'd0, 1'b0,2'b10,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b1,1'b0,3'd2);
    // trap coincident with a mismatching LPAD commit: trap wins
    vec(1'b1,1'b1,5'd10,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,3'd2);
    vec(1'b1,1'b0,5'd0, 1'b1,2'b00,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b1,1'b0,3'd2);
    vec(1'b1,1'b0,5'd0, 1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,3'd2);
    // debug entry drops ARMED, no arming or faults in debug
    vec(1'b1,1'b1,5'd10,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,3'd2);
    vec(1'b1,1'b0,5'd3, 1'b0,2'b10,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,3'd2);
    vec(1'b1,1'b1,5'd10,1'b0,2'b10,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,3'd2);
    vec(1'b1,1'b0,5'd3, 1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,3'd2);
    // landing pads disabled
    vec(1'b1,1'b1,5'd10,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,3'd2);
    vec(1'b0,1'b0,5'd0, 1'b0,2'b10,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,3'd2);
    vec(1'b1,1'b1,5'd10,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,3'd2);
    vec(1'b0,1'b0,5'd0, 1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,3'd2);
    vec(1'b1,1'b0,5'd3, 1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,3'd2);
    // xret with pelp_i=0 from ARMED
    vec(1'b1,1'b1,5'd10,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,3'd2);
    vec(1'b0,1'b0,5'd0, 1'b0,2'b10,1'b0,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b0,3'd2);
    // FAULT survives xlpad_i deassertion
    vec(1'b1,1'b1,5'd10,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,3'd2);
    vec(1'b1,1'b0,5'd3, 1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1,3'd3);
    vec(1'b0,1'b0,5'd0, 1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,3'd3);
    vec(1'b0,1'b0,5'd0, 1'b0,2'b10,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b1,1'b0,3'd3);
    // 8 more faults: 11 total = 2^3+3, counter saturates at 7
    for (int k = 1; k <= 8; k++) begin
      c = (3 + k > 7) ? 3'd7 : CW'(3 + k);
      vec(1'b1,1'b1,5'd10,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,
          (3 + k - 1 > 7) ? 3'd7 : CW'(3 + k - 1));
      vec(1'b1,1'b0,5'd3, 1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1,c);
      vec(1'b0,1'b0,5'd0, 1'b0,2'b10,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b1,1'b0,c);
    end
    // arm, then asynchronous reset mid-ARMED
    vec(1'b1,1'b1,5'd10,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,3'd7);
    @(posedge clk_i);
    #3;
    idle_in();
    push(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    stim_done = 1'b1;
  end

endmodule
